// File: rtl/cla_4b_core.sv
// Combinational 4-bit carry-lookahead adder. Every carry is a flat sum of
// products of g/p/cin, so no carry depends on a lower carry.
module cla_4b_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       gg,
    output logic       gp
);

    localparam int W = 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);

        sum  = p ^ c[W-1:0];
        cout = c[W];

        // Group terms exclude cin so a second-level lookahead unit can combine nibbles.
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
    end

endmodule

// File: rtl/cla_4b.sv
// Registered 4-bit carry-lookahead adder: {cout,sum} = a + b + cin, one cycle
// of latency, one result per cycle, synchronous active-high reset.
module cla_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    localparam int W = 4;

    logic [W-1:0] core_sum;
    logic         core_cout;
    logic [W-1:0] sum_d;
    logic [W-1:0] sum_q;
    logic         cout_d;
    logic         cout_q;

    // Group generate/propagate are reserved for a future 16-bit cascade.
    cla_4b_core u_core (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (core_sum),
        .cout (core_cout),
        .gg   (),
        .gp   ()
    );

    always_comb begin
        sum_d  = core_sum;
        cout_d = core_cout;
        if (rst) begin
            sum_d  = '0;
            cout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_cla_4b.sv
// Scoreboard bench for cla_4b: the driver pushes the arithmetic result of each
// applied vector, the monitor pops one entry per registered output.
module tb_cla_4b;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];

    cla_4b dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // Clock/reset: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ref_add(input logic r, input logic [3:0] x,
                                           input logic [3:0] y, input logic ci);
        int total;
        if (r) return 5'd0;
        total = int'(x) + int'(y) + int'(ci);
        return total[4:0];
    endfunction

    // Inputs change on the falling edge; the next rising edge captures them.
    task automatic drive(input logic r, input logic [3:0] x,
                         input logic [3:0] y, input logic ci);
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        cin = ci;
        exp_q.push_back(ref_add(r, x, y, ci));
    endtask

    // Monitor: each rising edge that follows a driven vector yields one result.
    always @(posedge clk) begin
        logic [4:0] exp_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== exp_v) begin
                failures++;
                $display("FAIL result t=%0t got cout=%b sum=%b expected cout=%b sum=%b",
                         $time, cout, sum, exp_v[4], exp_v[3:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        a   = 4'hf;
        b   = 4'hf;
        cin = 1'b1;

        // Reset with all-ones inputs must still clear the outputs.
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b0, 4'b0100, 4'b1001, 1'b1);
        drive(1'b0, 4'b0011, 4'b1000, 1'b0);
        drive(1'b0, 4'b1001, 4'b0110, 1'b1);
        drive(1'b0, 4'b0111, 4'b0001, 1'b1);
        drive(1'b0, 4'b1111, 4'b1111, 1'b1);

        // Exhaustive sweep with a single-cycle reset inserted part way through.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            if (i == 300) drive(1'b1, 4'($urandom_range(0, 15)),
                                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            drive(1'b0, v[8:5], v[4:1], v[0]);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)));
        end

        drive(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_4b.md
CLA_4B -- requirements
Module: cla_4b

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  4  unsigned addend A.
REQ-005 b  input  4  unsigned addend B.
REQ-006 cin  input  1  carry-in.
REQ-007 sum  output  4  registered sum bits [3:0].
REQ-008 cout  output  1  registered carry-out (bit 4 of result).
REQ-009 One clock; reset is synchronous and active-high.

Function
REQ-010 The block SHALL compute {cout,sum} = a + b + cin, 5-bit unsigned, no overflow loss.
REQ-011 The block SHALL form per-bit generate g[i]=a[i]&b[i] and propagate p[i]=a[i]^b[i].
REQ-012 Carries SHALL be lookahead, each expressed directly from g, p and cin, with no ripple chain:
  - c1=g0|p0·cin
  - c2=g1|p1·g0|p1·p0·cin
  - c3, c4 (=cout) expanded likewise.
REQ-013 The block SHALL compute sum[i]=p[i]^c[i], with c0=cin.
REQ-014 Inputs SHALL be sampled at each rising clk edge; sum/cout SHALL update at that same edge (latency 1 cycle, throughput 1 result/cycle).
REQ-015 Outputs SHALL hold their value between edges, with no combinational path from inputs to outputs.
REQ-016 There is no handshake; every cycle's inputs produce a result one cycle later.
REQ-017 Boundary cases:
  - 15+15+1 SHALL give sum=1111, cout=1.
  - 0+0+0 SHALL give sum=0000, cout=0.
  - A carry propagating through all 4 bits (p=1111, cin=1) SHALL give sum=0000, cout=1.
REQ-018 X-free inputs SHALL always yield X-free outputs.

Reset
REQ-019 When rst=1 at a rising edge, sum SHALL become 0000 and cout SHALL become 0, regardless of a/b/cin.
REQ-020 Reset asserted mid-stream SHALL discard the pending result, and outputs SHALL read zero on the edge following assertion.
REQ-021 On the first edge with rst=0, the block SHALL register the current inputs' result normally.
REQ-022 No other state exists.

Structure
REQ-023 No shared package is required; the width constant (4) SHALL be a local constant.
REQ-024 The combinational lookahead logic SHALL reside in one sub-module, cla_4b_core, with ports a, b, cin, sum, cout and no clock.
REQ-025 cla_4b SHALL wrap cla_4b_core with an output register stage holding sum and cout.
REQ-026 cla_4b_core SHALL additionally expose group generate (gg) and group propagate (gp) for future cascading into 16-bit adders; cla_4b SHALL leave these unconnected.

Verification
REQ-027 Reset: drive rst=1 with a=1111, b=1111, cin=1 -> sum=0000, cout=0 after the edge.
REQ-028 a=0000, b=0000, cin=0 -> sum=0000, cout=0 one cycle later.
REQ-029 Back-to-back vectors, one per cycle, each result one cycle later:
  - a=0100, b=1001, cin=1 -> sum=1110, cout=0
  - a=0011, b=1000, cin=0 -> sum=1011, cout=0
REQ-030 a=1001, b=0110, cin=1 -> sum=0000, cout=1 (full propagate chain).
REQ-031 a=0111, b=0001, cin=1 -> sum=1001, cout=0; then a=1111, b=1111, cin=1 -> sum=1111, cout=1.
REQ-032 Exhaustive sweep of all 512 a/b/cin combinations SHALL match the reference a+b+cin with 1-cycle latency.
REQ-033 Assert rst for one cycle mid-sweep -> zero outputs that cycle, then correct resumption.
